cache_ctrl_v2: RTL and testbench
================================

# cache_ctrl_v2

Parametrised second-generation cache control FSM sitting between the cache datapath (tag/dirty lookup) and the memory interface. It sequences hits, misses with victim writeback performed *before* the refill, and whole-cache flushes over a configurable number of lines. It also adds a memory-response timeout with error reporting. The datapath uses `flush_idx` to address the line being flushed and the `mem_*` strobes to drive the memory port.

## Interface
- `IDX_W`, default 4: flush index width; the cache has `NUM_LINES = 2**IDX_W` lines.
- `TIMEOUT`, default 255: max cycles waiting for `mem_done` in any memory state; 0 disables the timeout.
- `TO_W`, default 8: timeout counter width; `TIMEOUT` must be < `2**TO_W`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enable_cache` in 1: access request, sampled in IDLE.
- `hit` in 1: lookup hit for current access.
- `victim_dirty` in 1: victim line of current miss is dirty.
- `flush_req` in 1: flush request, sampled in IDLE.
- `line_dirty` in 1: line at `flush_idx` is dirty, sampled in FL_CHECK.
- `mem_done` in 1: memory completes current transfer (1-cycle pulse).
- `mem_en` out 1: memory transfer active (level).
- `mem_wr` out 1: 1 = write (writeback), 0 = read (fill); valid while `mem_en`.
- `idle` out 1: controller in IDLE.
- `fill_done` out 1: refill complete pulse.
- `hit_done` out 1: hit serviced pulse.
- `line_flushed` out 1: one flush line finished pulse.
- `flush_done` out 1: whole flush finished pulse.
- `mem_err` out 1: timeout pulse.
- `flush_idx` out IDX_W: line index currently being flushed.

## Operation
- States: IDLE, HIT, WB, FILL, FL_CHECK, FL_WB.
- Level outputs are decoded from state only:
  - `idle` = IDLE.
  - `mem_en` = WB | FILL | FL_WB.
  - `mem_wr` = WB | FL_WB.
- Pulse outputs are combinational, asserted in the cycle the qualifying condition holds.
- IDLE transitions, in priority order:
  - `flush_req` -> FL_CHECK with `flush_idx` = 0.
  - Else `enable_cache & hit` -> HIT.
  - Else `enable_cache & !hit & victim_dirty` -> WB.
  - Else `enable_cache & !hit` -> FILL.
  - Else stay in IDLE.
- HIT: `hit_done` = 1, next state IDLE unconditionally.
- WB: on `mem_done` -> FILL. No `fill_done` here.
- FILL: on `mem_done`, `fill_done` = 1 and next state IDLE.
- FL_CHECK:
  - `line_dirty` -> FL_WB.
  - Else `line_flushed` = 1, then the last-line rule applies.
- FL_WB: on `mem_done`, `line_flushed` = 1, then the last-line rule applies.
- Last-line rule:
  - If `flush_idx == NUM_LINES-1`: `flush_done` = 1 in the same cycle, `flush_idx` -> 0, next state IDLE.
  - Else `flush_idx` increments by 1 and next state is FL_CHECK.
- Timeout counter:
  - Cleared on every entry into WB, FILL or FL_WB; increments each cycle in those states while `mem_done` = 0.
  - If `TIMEOUT != 0` and the count equals `TIMEOUT` with `mem_done` = 0: `mem_err` = 1, next state IDLE, `flush_idx` -> 0 (flush aborted).
  - `mem_done` in the same cycle wins over timeout.
- `mem_done` outside WB/FILL/FL_WB is ignored.
- `flush_req`/`enable_cache` outside IDLE are ignored; the requester holds them until `idle` is seen.

## Timing
- Reset (`rst` = 0, any time, including mid-transfer or mid-flush):
  - state IDLE, `flush_idx` = 0, timeout counter = 0.
  - `idle` = 1; all other outputs 0.
  - An in-flight memory transfer is abandoned.
- Hit: request accepted at cycle N, `hit_done` at N+1, IDLE at N+2.
- Clean miss:
  - `mem_en` = 1 and `mem_wr` = 0 from N+1.
  - `fill_done` in the `mem_done` cycle; IDLE the cycle after.
- Dirty miss:
  - WB (`mem_wr` = 1) from N+1.
  - FILL the cycle after the WB `mem_done`.
  - `mem_en` stays high across the WB->FILL boundary; `mem_wr` drops.
- Flush:
  - A clean line costs 1 cycle.
  - A dirty line costs 1 + (memory latency) cycles; `mem_en` rises the cycle after FL_CHECK.
  - All-clean flush of 16 lines: FL_CHECK for 16 cycles, `flush_done` on the 16th, `idle` on the 17th.
- `flush_idx` is stable throughout FL_WB.
- Timeout fires in the cycle when the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after state entry.

## Test plan
- Reset mid-FL_WB with `flush_idx` = 5 -> next cycle `idle` = 1, `flush_idx` = 0, `mem_en` = 0.
- Hit: `enable_cache` = 1, `hit` = 1 -> `hit_done` pulse 1 cycle later, no `mem_en`.
- Dirty miss, memory latency 3 for each transfer:
  - `mem_en` = `mem_wr` = 1 for 3 cycles.
  - Then `mem_wr` = 0 with `mem_en` held.
  - `fill_done` on the second `mem_done`; exactly one `fill_done`.
- Flush, IDX_W=4, lines 0 and 15 dirty:
  - Writebacks at `flush_idx` 0 and 15.
  - 16 `line_flushed` pulses, single `flush_done` coincident with the last one, ends at `flush_idx` = 0.
- `flush_req` and `enable_cache` both high in IDLE -> flush taken, access ignored until `idle` returns.
- TIMEOUT=4, FILL with no `mem_done` -> `mem_err` on the 5th FILL cycle, then IDLE, no `fill_done`.
- TIMEOUT=4, `mem_done` on that same 5th cycle -> `fill_done` = 1, `mem_err` = 0.

Source files
------------

// File: rtl/cache_ctrl_v2.sv
// Cache control FSM: hits, misses with writeback-before-refill, whole-cache flush,
// and a memory-response timeout that aborts the current operation.
module cache_ctrl_v2 #(
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_cache,
    input  logic             hit,
    input  logic             victim_dirty,
    input  logic             flush_req,
    input  logic             line_dirty,
    input  logic             mem_done,
    output logic             mem_en,
    output logic             mem_wr,
    output logic             idle,
    output logic             fill_done,
    output logic             hit_done,
    output logic             line_flushed,
    output logic             flush_done,
    output logic             mem_err,
    output logic [IDX_W-1:0] flush_idx
);

    // state    | meaning
    // IDLE     | waiting for flush or access request
    // HIT      | hit serviced this cycle
    // WB       | victim writeback to memory
    // FILL     | refill read from memory
    // FL_CHECK | inspect line at flush_idx
    // FL_WB    | write back dirty line at flush_idx
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HIT      = 3'd1;
    localparam logic [2:0] S_WB       = 3'd2;
    localparam logic [2:0] S_FILL     = 3'd3;
    localparam logic [2:0] S_FL_CHECK = 3'd4;
    localparam logic [2:0] S_FL_WB    = 3'd5;

    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);
    localparam bit               TO_ON    = (TIMEOUT != 0);
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [IDX_W-1:0] idx_nx;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_nx;
    logic             in_mem;
    logic             timed_out;
    logic             last_line;
    logic             line_end;

    assign in_mem    = (state == S_WB) || (state == S_FILL) || (state == S_FL_WB);
    assign timed_out = TO_ON && in_mem && !mem_done && (to_cnt == TO_LIM);
    assign last_line = (flush_idx == IDX_LAST);

    assign idle   = (state == S_IDLE);
    assign mem_en = in_mem;
    assign mem_wr = (state == S_WB) || (state == S_FL_WB);

    always_comb begin
        state_nx  = state;
        idx_nx    = flush_idx;
        line_end  = 1'b0;
        hit_done  = 1'b0;
        fill_done = 1'b0;
        mem_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush_req) begin
                    state_nx = S_FL_CHECK;
                    idx_nx   = '0;
                end else if (enable_cache) begin
                    if (hit)
                        state_nx = S_HIT;
                    else if (victim_dirty)
                        state_nx = S_WB;
                    else
                        state_nx = S_FILL;
                end
            end
            S_HIT: begin
                hit_done = 1'b1;
                state_nx = S_IDLE;
            end
            S_WB: begin
                if (mem_done) begin
                    state_nx = S_FILL;
                end else if (timed_out) begin
                    mem_err  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_FILL: begin
                if (mem_done) begin
                    fill_done = 1'b1;
                    state_nx  = S_IDLE;
                end else if (timed_out) begin
                    mem_err  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_FL_CHECK: begin
                if (line_dirty)
                    state_nx = S_FL_WB;
                else
                    line_end = 1'b1;
            end
            S_FL_WB: begin
                if (mem_done) begin
                    line_end = 1'b1;
                end else if (timed_out) begin
                    mem_err  = 1'b1;
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Shared end-of-line handling for clean lines and completed writebacks.
        if (line_end) begin
            if (last_line) begin
                idx_nx   = '0;
                state_nx = S_IDLE;
            end else begin
                idx_nx   = flush_idx + IDX_W'(1);
                state_nx = S_FL_CHECK;
            end
        end
    end

    assign line_flushed = line_end;
    assign flush_done   = line_end && last_line;

    // Any state change clears the counter, so each memory state entry starts from zero.
    always_comb begin
        to_cnt_nx = to_cnt;
        if (state_nx != state)
            to_cnt_nx = '0;
        else if (in_mem && !mem_done)
            to_cnt_nx = to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            flush_idx <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nx;
            flush_idx <= idx_nx;
            to_cnt    <= to_cnt_nx;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_v2.sv
// Self-checking bench for cache_ctrl_v2 (IDX_W=4, TIMEOUT=4): per-cycle expected
// output vectors go through a scoreboard queue and are compared at mid-cycle.
module tb_cache_ctrl_v2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable_cache = 1'b0;
    logic       hit = 1'b0;
    logic       victim_dirty = 1'b0;
    logic       flush_req = 1'b0;
    logic       line_dirty = 1'b0;
    logic       mem_done = 1'b0;
    logic       mem_en, mem_wr, idle, fill_done, hit_done;
    logic       line_flushed, flush_done, mem_err;
    logic [3:0] flush_idx;

    // {idle, mem_en, mem_wr, hit_done, fill_done, line_flushed, flush_done, mem_err, flush_idx}
    logic [11:0] obs;
    logic [11:0] sb[$];
    logic [5:0]  tbl_s[$];
    logic [11:0] tbl_e[$];
    int          n_cmp = 0;
    int          n_err = 0;

    cache_ctrl_v2 #(.IDX_W(4), .TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .enable_cache(enable_cache), .hit(hit),
        .victim_dirty(victim_dirty), .flush_req(flush_req), .line_dirty(line_dirty),
        .mem_done(mem_done), .mem_en(mem_en), .mem_wr(mem_wr), .idle(idle),
        .fill_done(fill_done), .hit_done(hit_done), .line_flushed(line_flushed),
        .flush_done(flush_done), .mem_err(mem_err), .flush_idx(flush_idx)
    );

    always #5 clk = ~clk;

    assign obs = {idle, mem_en, mem_wr, hit_done, fill_done, line_flushed,
                  flush_done, mem_err, flush_idx};

    function automatic logic [11:0] ev(bit i, bit me, bit mw, bit hd, bit fd,
                                       bit lf, bit fdn, bit er, int idx);
        return {i, me, mw, hd, fd, lf, fdn, er, 4'(idx)};
    endfunction

    // {enable_cache, hit, victim_dirty, flush_req, line_dirty, mem_done}
    function automatic logic [5:0] st(bit en, bit h, bit vd, bit fr, bit ld, bit md);
        return {en, h, vd, fr, ld, md};
    endfunction

    task automatic row(input logic [5:0] s, input logic [11:0] e);
        tbl_s.push_back(s);
        tbl_e.push_back(e);
    endtask

    task automatic clear_tbl();
        tbl_s.delete();
        tbl_e.delete();
    endtask

    task automatic apply(input logic [5:0] s, input logic [11:0] e);
        @(negedge clk);
        {enable_cache, hit, victim_dirty, flush_req, line_dirty, mem_done} = s;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 1, 0, 1, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(1, 0, 1, 0, 1, 1), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL reset c%0d got %b want %b", i, obs, want);
            end
        end
        {enable_cache, hit, victim_dirty, flush_req, line_dirty, mem_done} = '0;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_flush();
        logic [11:0] want;
        clear_tbl();
        row(st(0, 0, 0, 1, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            row(st(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 1, 0, 0, k));
        row(st(0, 0, 0, 0, 1, 0), ev(0, 0, 0, 0, 0, 0, 0, 0, 5));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 5));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 5));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL rst_mid_flush c%0d got %b want %b", i, obs, want);
            end
        end
        sb.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        #1;
        want = sb.pop_front();
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL rst_mid_flush async got %b want %b", obs, want);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        want = sb.pop_front();
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL rst_mid_flush after got %b want %b", obs, want);
        end
    endtask

    task automatic test_hit();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 1, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 1, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL hit c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_clean_miss();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 0, 0, 1, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL clean_miss c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_dirty_miss();
        logic [11:0] want;
        int          fills = 0;
        clear_tbl();
        row(st(1, 0, 1, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 0, 0, 1, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            if (fill_done === 1'b1) fills++;
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL dirty_miss c%0d got %b want %b", i, obs, want);
            end
        end
        n_cmp++;
        if (fills !== 1) begin
            n_err++;
            $display("FAIL dirty_miss fill_count got %0d want 1", fills);
        end
    endtask

    task automatic test_flush_dirty();
        logic [11:0] want;
        int          lf_cnt = 0;
        int          fd_cnt = 0;
        clear_tbl();
        row(st(0, 0, 0, 1, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 1, 0), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 1, 0, 0, 1, 0, 0, 0));
        for (int k = 1; k < 15; k++)
            row(st(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 1, 0, 0, k));
        row(st(0, 0, 0, 0, 1, 0), ev(0, 0, 0, 0, 0, 0, 0, 0, 15));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 15));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 1, 0, 0, 1, 1, 0, 15));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            if (line_flushed === 1'b1) lf_cnt++;
            if (flush_done === 1'b1) fd_cnt++;
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL flush_dirty c%0d got %b want %b", i, obs, want);
            end
        end
        n_cmp++;
        if (lf_cnt !== 16 || fd_cnt !== 1) begin
            n_err++;
            $display("FAIL flush_dirty pulse_counts got lf=%0d fd=%0d want lf=16 fd=1",
                     lf_cnt, fd_cnt);
        end
    endtask

    task automatic test_priority();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 1, 0, 1, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 15; k++)
            row(st(1, 1, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 1, 0, 0, k));
        row(st(1, 1, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 1, 1, 0, 15));
        row(st(1, 1, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 1, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL priority c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_timeout_fill();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 1, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL timeout_fill c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_timeout_race();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 0, 0, 1, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL timeout_race c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_timeout_flush();
        logic [11:0] want;
        clear_tbl();
        row(st(0, 0, 0, 1, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 1, 0, 0, 0));
        row(st(0, 0, 0, 0, 1, 0), ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 4; k++)
            row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 0, 1));
        row(st(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0, 0, 1, 1));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL timeout_flush c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] want;
        clear_tbl();
        row(st(1, 1, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(1, 1, 0, 0, 0, 0), ev(0, 0, 0, 1, 0, 0, 0, 0, 0));
        row(st(1, 0, 1, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        row(st(1, 0, 1, 0, 0, 1), ev(0, 1, 1, 0, 0, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 1), ev(0, 1, 0, 0, 1, 0, 0, 0, 0));
        row(st(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl_s[i]) begin
            apply(tbl_s[i], tbl_e[i]);
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL back_to_back c%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_flush_dirty();
        test_priority();
        test_timeout_fill();
        test_timeout_race();
        test_timeout_flush();
        test_back_to_back();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
